// File: rtl/dapa_pkg.sv
// Shared definitions for the DAPA core: default widths, instruction fields,
// opcodes and the fetch-unit state encoding.
package dapa_pkg;

  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 16;
  localparam int CNT_W      = 16;

  // Instruction word layout: [15:11] opcode, [10:8] Rf, [7:0] operand
  localparam int OPC_MSB  = 15;
  localparam int OPC_LSB  = 11;
  localparam int RF_MSB   = 10;
  localparam int RF_LSB   = 8;
  localparam int OPND_MSB = 7;
  localparam int OPND_LSB = 0;

  localparam logic [4:0] OP_LDI  = 5'b11111;
  localparam logic [4:0] OP_STS  = 5'b00010;
  localparam logic [4:0] OP_LDS  = 5'b00011;
  localparam logic [4:0] OP_STOP = 5'b10111;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } fetch_state_e;

  function automatic logic is_stop(input logic [DEF_DATA_W-1:0] word);
    return word[OPC_MSB:OPC_LSB] == OP_STOP;
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Bundle between the fetch unit, program memory and execute stage.
// The fetch unit takes the master modport; memory/execute side takes slave.
interface fetch_unit_if
  import dapa_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic [DATA_W-1:0] ir;
  logic              ir_valid;
  logic              ir_ready;
  logic              jump_en;
  logic [ADDR_W-1:0] jump_addr;
  logic              resume;
  logic [ADDR_W-1:0] pc;
  logic              halted;
  logic [CNT_W-1:0]  fetch_count;

  modport master (
    output mem_addr, ir, ir_valid, pc, halted, fetch_count,
    input  mem_data, ir_ready, jump_en, jump_addr, resume
  );

  modport slave (
    input  mem_addr, ir, ir_valid, pc, halted, fetch_count,
    output mem_data, ir_ready, jump_en, jump_addr, resume
  );

endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: single-entry IR with ready/valid handoff, jump
// redirect, STOP/resume halt control. Optional FETCH_COUNT_EN adds a
// saturating capture counter.
module fetch_unit
  import dapa_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input logic         clk,
  input logic         reset,
  fetch_unit_if.master bus
);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic              ir_valid_q, ir_valid_d;
  logic              halted_q, halted_d;
  logic              capture;

  // A new word may enter the IR only while running, not redirecting, and
  // when the current IR is either empty or being consumed this cycle.
  assign capture = (state_q == ST_RUN) && !bus.jump_en &&
                   (!ir_valid_q || bus.ir_ready);

  // NOTE: every _d gets its default first so no path leaves it unassigned
  // (which would infer a latch); blocking '=' is correct in always_comb.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    ir_valid_d = ir_valid_q;

    if (bus.jump_en) begin
      pc_d       = bus.jump_addr;
      ir_valid_d = 1'b0;
      state_d    = ST_RUN;
    end else if (capture) begin
      ir_d       = bus.mem_data;
      ir_valid_d = 1'b1;
      pc_d       = pc_q + ADDR_W'(1);
      if (is_stop(bus.mem_data)) state_d = ST_HALT;
    end else begin
      if (ir_valid_q && bus.ir_ready) ir_valid_d = 1'b0;
      if (state_q == ST_HALT && bus.resume) state_d = ST_RUN;
    end

    halted_d = (state_d == ST_HALT);
  end

  // NOTE: sequential state uses non-blocking '<=' so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_RUN;
      pc_q       <= '0;
      ir_q       <= '0;
      ir_valid_q <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      ir_valid_q <= ir_valid_d;
      halted_q   <= halted_d;
    end
  end

`ifdef FETCH_COUNT_EN
  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (capture && count_q != {CNT_W{1'b1}}) count_d = count_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign bus.fetch_count = count_q;
`else
  assign bus.fetch_count = '0;
`endif

  assign bus.mem_addr = pc_q;
  assign bus.pc       = pc_q;
  assign bus.ir       = ir_q;
  assign bus.ir_valid = ir_valid_q;
  assign bus.halted   = halted_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed plus randomized bench for fetch_unit, checked every cycle against
// a transaction-level reference model of the fetch rules.
module tb_fetch_unit;
  import dapa_pkg::*;

  logic clk = 1'b0;
  logic reset;
  logic [15:0] mem [256];

  int total = 0;
  int bad   = 0;

  // Reference model state
  int m_pc, m_ir, m_valid, m_halt, m_cnt;

  fetch_unit_if bus ();

  fetch_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  assign bus.mem_data = mem[bus.mem_addr];

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Applies the fetch rules to the model using the inputs present at the edge.
  task automatic model_step();
    int word;
    if (reset) begin
      m_pc = 0; m_ir = 0; m_valid = 0; m_halt = 0; m_cnt = 0;
    end else if (bus.jump_en) begin
      m_pc = int'(bus.jump_addr);
      m_valid = 0;
      m_halt = 0;
    end else if (m_halt == 0 && (m_valid == 0 || bus.ir_ready)) begin
      word    = int'(mem[m_pc]);
      m_ir    = word;
      m_valid = 1;
      m_pc    = (m_pc + 1) % 256;
`ifdef FETCH_COUNT_EN
      if (m_cnt < 65535) m_cnt = m_cnt + 1;
`endif
      if ((word / 2048) == 23) m_halt = 1;
    end else begin
      if (m_valid == 1 && bus.ir_ready) m_valid = 0;
      if (m_halt == 1 && bus.resume) m_halt = 0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check("pc",          32'(bus.pc),          32'(m_pc));
    check("mem_addr",    32'(bus.mem_addr),    32'(m_pc));
    check("ir",          32'(bus.ir),          32'(m_ir));
    check("ir_valid",    32'(bus.ir_valid),    32'(m_valid));
    check("halted",      32'(bus.halted),      32'(m_halt));
    check("fetch_count", 32'(bus.fetch_count), 32'(m_cnt));
  endtask

  int exp_cnt5;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    mem[0] = 16'hF8AA; mem[1] = 16'h1080; mem[2] = 16'h1983;
    mem[3] = 16'h1081; mem[4] = 16'hB800; mem[5] = 16'h1234;
    mem[255] = 16'h1080;
`ifdef FETCH_COUNT_EN
    exp_cnt5 = 5;
`else
    exp_cnt5 = 0;
`endif

    reset = 1'b1;
    bus.ir_ready = 1'b1; bus.jump_en = 1'b0; bus.jump_addr = '0; bus.resume = 1'b0;
    tick(); tick();
    check("rst_pc", 32'(bus.pc), 32'h0);
    check("rst_valid", 32'(bus.ir_valid), 32'h0);

    // Straight-line fetch from address 0
    reset = 1'b0;
    tick(); check("seq_ir0", 32'(bus.ir), 32'hF8AA);
    tick(); check("seq_ir1", 32'(bus.ir), 32'h1080);

    // Back-pressure holds IR and PC
    bus.ir_ready = 1'b0;
    tick(); tick(); tick();
    check("stall_ir", 32'(bus.ir), 32'h1080);
    check("stall_pc", 32'(bus.pc), 32'h02);
    bus.ir_ready = 1'b1;
    tick(); check("unstall_ir", 32'(bus.ir), 32'h1983);

    // Jump discards unconsumed IR
    bus.ir_ready = 1'b0; bus.jump_en = 1'b1; bus.jump_addr = 8'h03;
    tick();
    check("jump_valid", 32'(bus.ir_valid), 32'h0);
    check("jump_pc", 32'(bus.pc), 32'h03);
    check("jump_ir_kept", 32'(bus.ir), 32'h1983);
    bus.jump_en = 1'b0; bus.ir_ready = 1'b1;
    tick(); check("after_jump_ir", 32'(bus.ir), 32'h1081);

    // STOP word halts but is still presented
    tick();
    check("stop_ir", 32'(bus.ir), 32'hB800);
    check("stop_valid", 32'(bus.ir_valid), 32'h1);
    check("stop_halted", 32'(bus.halted), 32'h1);
    check("stop_pc", 32'(bus.pc), 32'h05);
    check("stop_cnt", 32'(bus.fetch_count), 32'(exp_cnt5));
    tick(); tick();
    check("halt_pc", 32'(bus.pc), 32'h05);
    check("halt_drained", 32'(bus.ir_valid), 32'h0);

    // Resume: RUN next cycle, capture the cycle after
    bus.resume = 1'b1;
    tick();
    check("resume_halted", 32'(bus.halted), 32'h0);
    check("resume_pc", 32'(bus.pc), 32'h05);
    bus.resume = 1'b0;
    tick(); check("resume_ir", 32'(bus.ir), 32'h1234);
    bus.resume = 1'b1;
    tick(); check("resume_run_pc", 32'(bus.pc), 32'h07);
    bus.resume = 1'b0;

    // Wrap from 0xFF to 0x00
    bus.jump_en = 1'b1; bus.jump_addr = 8'hFF;
    tick();
    bus.jump_en = 1'b0;
    tick();
    check("wrap_ir", 32'(bus.ir), 32'h1080);
    check("wrap_pc", 32'(bus.pc), 32'h00);

    // Reset overrides a simultaneous jump
    reset = 1'b1; bus.jump_en = 1'b1; bus.jump_addr = 8'h40;
    tick();
    check("rstjmp_pc", 32'(bus.pc), 32'h0);
    check("rstjmp_valid", 32'(bus.ir_valid), 32'h0);
    check("rstjmp_cnt", 32'(bus.fetch_count), 32'h0);
    reset = 1'b0; bus.jump_en = 1'b0;
    tick(); check("post_rst_ir", 32'(bus.ir), 32'hF8AA);

    // Randomized traffic against the model
    for (int i = 0; i < 256; i++)
      mem[i] = ($urandom_range(0, 15) == 0) ? {OP_STOP, 11'($urandom)} : 16'($urandom);
    for (int c = 0; c < 2000; c++) begin
      reset         = ($urandom_range(0, 199) == 0);
      bus.ir_ready  = ($urandom_range(0, 9) < 7);
      bus.jump_en   = ($urandom_range(0, 19) == 0);
      bus.jump_addr = 8'($urandom);
      bus.resume    = ($urandom_range(0, 4) == 0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter ADDR_W, 8, program memory address width and PC width.
REQ-002 Parameter DATA_W, 16, instruction word width.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 mem_addr  output  ADDR_W  address to the combinational program memory.
REQ-006 mem_data  input  DATA_W  instruction word returned by memory in the same cycle.
REQ-007 ir  output  DATA_W  instruction register presented to the execute stage.
REQ-008 ir_valid  output  1  ir holds an unconsumed instruction.
REQ-009 ir_ready  input  1  execute stage accepts ir this cycle.
REQ-010 jump_en  input  1  redirect fetch to jump_addr.
REQ-011 jump_addr  input  ADDR_W  redirect target.
REQ-012 resume  input  1  leave HALT.
REQ-013 pc  output  ADDR_W  address of next word to fetch.
REQ-014 halted  output  1  unit is in HALT.
REQ-015 fetch_count  output  16  fetched-instruction counter (see Configuration).

Function
REQ-016 mem_addr SHALL equal pc combinationally at all times.
REQ-017 States SHALL be RUN and HALT; halted SHALL be 1 exactly in HALT.
REQ-018 Capture condition: RUN, jump_en=0, and (ir_valid=0 or ir_ready=1).
REQ-019 On capture: ir<=mem_data, ir_valid<=1, pc<=pc+1; sustained throughput SHALL be one instruction per cycle with ir_ready held high.
REQ-020 ir_valid=1 and ir_ready=0 SHALL hold ir, ir_valid and pc unchanged.
REQ-021 ir_valid=1, ir_ready=1, no capture possible SHALL clear ir_valid next cycle.
REQ-022 pc increment SHALL wrap modulo 2^ADDR_W (0xFF -> 0x00).
REQ-023 jump_en=1 (any state) SHALL set pc<=jump_addr, ir_valid<=0, state<=RUN next cycle, discarding any unconsumed ir; jump has priority over capture, STOP and resume.
REQ-024 Capturing a word with ir[15:11]=OP_STOP (5'b10111) SHALL set state<=HALT in the same edge; the STOP word SHALL still be presented on ir with ir_valid=1 until consumed.
REQ-025 In HALT no capture SHALL occur and pc SHALL stay at STOP address+1.
REQ-026 resume=1 in HALT with jump_en=0 SHALL return to RUN next cycle; capture resumes the cycle after; resume in RUN SHALL be ignored.
REQ-027 ir SHALL not change when ir_valid drops; only ir_valid signals validity.

Reset
REQ-028 reset=1 SHALL override all inputs, including jump_en and resume.
REQ-029 Reset values: pc=0, ir=0, ir_valid=0, state=RUN, halted=0, fetch_count=0.
REQ-030 First capture SHALL occur on the first edge after reset deasserts, from address 0x00.

Configuration
REQ-031 Macro FETCH_COUNT_EN defined: fetch_count SHALL increment by 1 on every capture, saturating at 0xFFFF, cleared only by reset.
REQ-032 FETCH_COUNT_EN undefined: fetch_count SHALL be constant 0 and no counter register SHALL be built.

Structure
REQ-033 Package dapa_pkg SHALL hold ADDR_W/DATA_W defaults, opcode field positions [15:11], Rf field [10:8], operand field [7:0], and opcode constants OP_LDI=5'b11111, OP_STS=5'b00010, OP_LDS=5'b00011, OP_STOP=5'b10111.
REQ-034 The state encoding SHALL be a package enum; no sub-module is required, fetch_unit is a single module.

Verification
REQ-035 Memory image 0:F8AA,1:1080,2:1983,3:1081,4:B800, ir_ready=1 -> ir sequence F8AA,1080,1983,1081,B800 on consecutive cycles, halted=1 after B800 capture, pc=0x05, fetch_count=5 (macro on).
REQ-036 ir_ready=0 for 3 cycles after 1080 captured -> ir stays 1080, pc stays 0x02, then 1983 on the cycle after ir_ready rises.
REQ-037 jump_en=1, jump_addr=0x03 while ir=1983 valid and ir_ready=0 -> next cycle ir_valid=0, pc=0x03; following cycle ir=1081.
REQ-038 HALT with pc=0x05, resume=1 one cycle -> RUN next cycle, word at 0x05 captured the cycle after; resume in RUN -> no effect.
REQ-039 jump_addr=0xFF, mem[0xFF]=1080 -> capture 1080, pc wraps to 0x00; reset asserted mid-run together with jump_en -> pc=0, ir_valid=0, fetch_count=0.
